// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_pkg
//  Description : Shared types and default widths for the CDB arbiter slice.
//  Revision    : 1.0
// ============================================================================
package cdb_pkg;

    localparam int CDB_DATA_W    = 3;
    localparam int CDB_ROB_IDX_W = 2;
    localparam int CDB_DEPTH     = 2;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } cdb_src_e;

    typedef struct packed {
        logic [CDB_ROB_IDX_W-1:0] rob_idx;
        logic [CDB_DATA_W-1:0]    value;
    } cdb_entry_t;

    function automatic cdb_src_e other_src(input cdb_src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_if
//  Description : Producer handshakes, CDB broadcast and status of the arbiter.
//  Revision    : 1.0
// ============================================================================
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int DATA_W    = CDB_DATA_W,
    parameter int ROB_IDX_W = CDB_ROB_IDX_W
);
    logic                 flush;
    logic                 alu_valid;
    logic [ROB_IDX_W-1:0] alu_rob_idx;
    logic [DATA_W-1:0]    alu_value;
    logic                 alu_ready;
    logic                 mem_valid;
    logic [ROB_IDX_W-1:0] mem_rob_idx;
    logic [DATA_W-1:0]    mem_value;
    logic                 mem_ready;
    logic                 cdb_valid;
    logic [ROB_IDX_W-1:0] cdb_rob_idx;
    logic [DATA_W-1:0]    cdb_value;
    cdb_src_e             cdb_src;
    logic                 idle;
    logic                 drop_err;

    modport master (
        output flush,
        output alu_valid, alu_rob_idx, alu_value,
        input  alu_ready,
        output mem_valid, mem_rob_idx, mem_value,
        input  mem_ready,
        input  cdb_valid, cdb_rob_idx, cdb_value, cdb_src,
        input  idle, drop_err
    );

    modport slave (
        input  flush,
        input  alu_valid, alu_rob_idx, alu_value,
        output alu_ready,
        input  mem_valid, mem_rob_idx, mem_value,
        output mem_ready,
        output cdb_valid, cdb_rob_idx, cdb_value, cdb_src,
        output idle, drop_err
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : result_fifo
//  Description : DEPTH-entry count-based FIFO with sync reset and clear.
//  Revision    : 1.0
// ============================================================================
module result_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] data_o,
    output logic                  empty_o,
    output logic                  full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Round-robin sharing of the registered CDB between ALU and MEM.
//  Revision    : 1.0
// ============================================================================
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W    = CDB_DATA_W,
    parameter int ROB_IDX_W = CDB_ROB_IDX_W,
    parameter int DEPTH     = CDB_DEPTH
) (
    input wire logic      clock,
    input wire logic      reset,
    cdb_arbiter_if.slave  bus
);
    localparam int ENT_W = ROB_IDX_W + DATA_W;

    logic [ENT_W-1:0]     alu_in, mem_in;
    logic [ENT_W-1:0]     alu_head, mem_head;
    logic [ENT_W-1:0]     alu_ent, mem_ent;
    logic                 alu_empty, alu_full, mem_empty, mem_full;
    logic                 alu_acc, mem_acc;
    logic                 alu_elig, mem_elig;
    logic                 alu_gnt, mem_gnt;
    logic                 alu_push, mem_push;
    logic                 alu_pop, mem_pop;

    cdb_src_e             rr_q, rr_d;
    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
    logic [DATA_W-1:0]    cdb_value_q, cdb_value_d;
    cdb_src_e             cdb_src_q, cdb_src_d;
    logic                 drop_err_q, drop_err_d;

    assign alu_in = {bus.alu_rob_idx, bus.alu_value};
    assign mem_in = {bus.mem_rob_idx, bus.mem_value};

    // Ready is purely count-based so it never combinationally depends on valid.
    assign bus.alu_ready = !alu_full;
    assign bus.mem_ready = !mem_full;

    assign alu_acc  = bus.alu_valid && !alu_full && !bus.flush;
    assign mem_acc  = bus.mem_valid && !mem_full && !bus.flush;
    assign alu_elig = !alu_empty || alu_acc;
    assign mem_elig = !mem_empty || mem_acc;
    assign alu_ent  = alu_empty ? alu_in : alu_head;
    assign mem_ent  = mem_empty ? mem_in : mem_head;

    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (alu_elig && mem_elig) begin
            if (rr_q == SRC_ALU) alu_gnt = 1'b1;
            else                 mem_gnt = 1'b1;
        end else begin
            alu_gnt = alu_elig;
            mem_gnt = mem_elig;
        end
    end

    // A granted input arriving at an empty FIFO bypasses storage entirely.
    assign alu_push = alu_acc && !(alu_empty && alu_gnt);
    assign mem_push = mem_acc && !(mem_empty && mem_gnt);
    assign alu_pop  = alu_gnt && !alu_empty;
    assign mem_pop  = mem_gnt && !mem_empty;

    result_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk     (clock),
        .rst     (reset),
        .clear_i (bus.flush),
        .push_i  (alu_push),
        .data_i  (alu_in),
        .pop_i   (alu_pop),
        .data_o  (alu_head),
        .empty_o (alu_empty),
        .full_o  (alu_full)
    );

    result_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_mem_fifo (
        .clk     (clock),
        .rst     (reset),
        .clear_i (bus.flush),
        .push_i  (mem_push),
        .data_i  (mem_in),
        .pop_i   (mem_pop),
        .data_o  (mem_head),
        .empty_o (mem_empty),
        .full_o  (mem_full)
    );

    always_comb begin
        rr_d = rr_q;
        if (bus.flush)    rr_d = SRC_ALU;
        else if (alu_gnt) rr_d = other_src(SRC_ALU);
        else if (mem_gnt) rr_d = other_src(SRC_MEM);
    end

    always_comb begin
        cdb_valid_d   = 1'b0;
        cdb_rob_idx_d = cdb_rob_idx_q;
        cdb_value_d   = cdb_value_q;
        cdb_src_d     = cdb_src_q;
        if (bus.flush) begin
            cdb_rob_idx_d = '0;
            cdb_value_d   = '0;
            cdb_src_d     = SRC_ALU;
        end else if (alu_gnt) begin
            cdb_valid_d   = 1'b1;
            cdb_rob_idx_d = alu_ent[ENT_W-1 -: ROB_IDX_W];
            cdb_value_d   = alu_ent[DATA_W-1:0];
            cdb_src_d     = SRC_ALU;
        end else if (mem_gnt) begin
            cdb_valid_d   = 1'b1;
            cdb_rob_idx_d = mem_ent[ENT_W-1 -: ROB_IDX_W];
            cdb_value_d   = mem_ent[DATA_W-1:0];
            cdb_src_d     = SRC_MEM;
        end
    end

    // Sticky until reset; flush deliberately leaves it set.
    assign drop_err_d = drop_err_q
                      || (bus.alu_valid && alu_full)
                      || (bus.mem_valid && mem_full);

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q          <= SRC_ALU;
            cdb_valid_q   <= 1'b0;
            cdb_rob_idx_q <= '0;
            cdb_value_q   <= '0;
            cdb_src_q     <= SRC_ALU;
            drop_err_q    <= 1'b0;
        end else begin
            rr_q          <= rr_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_rob_idx_q <= cdb_rob_idx_d;
            cdb_value_q   <= cdb_value_d;
            cdb_src_q     <= cdb_src_d;
            drop_err_q    <= drop_err_d;
        end
    end

    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_rob_idx = cdb_rob_idx_q;
    assign bus.cdb_value   = cdb_value_q;
    assign bus.cdb_src     = cdb_src_q;
    assign bus.drop_err    = drop_err_q;
    assign bus.idle        = alu_empty && mem_empty && !cdb_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Scoreboard bench for cdb_arbiter with directed and random traffic.
//  Revision    : 1.0
// ============================================================================
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cdb_entry_t qa[$];
    cdb_entry_t qm[$];

    cdb_arbiter_if #(.DATA_W(CDB_DATA_W), .ROB_IDX_W(CDB_ROB_IDX_W)) bus ();

    cdb_arbiter #(
        .DATA_W    (CDB_DATA_W),
        .ROB_IDX_W (CDB_ROB_IDX_W),
        .DEPTH     (CDB_DEPTH)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [1:0] ai, input logic [2:0] ad,
                         input logic mv, input logic [1:0] mi, input logic [2:0] md);
        bus.alu_valid   = av;
        bus.alu_rob_idx = ai;
        bus.alu_value   = ad;
        bus.mem_valid   = mv;
        bus.mem_rob_idx = mi;
        bus.mem_value   = md;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0);
        bus.flush = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int waited;
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0);
        bus.flush = 1'b0;
        waited = 0;
        while (!bus.idle && waited < 20) begin
            tick();
            waited++;
        end
        check_val(tag, 32'(bus.idle), 32'd1);
    endtask

    // Expected results are captured at the accepting edge.
    always @(posedge clk) begin
        if (rst || bus.flush) begin
            qa.delete();
            qm.delete();
        end else begin
            if (bus.alu_valid && bus.alu_ready) qa.push_back('{bus.alu_rob_idx, bus.alu_value});
            if (bus.mem_valid && bus.mem_ready) qm.push_back('{bus.mem_rob_idx, bus.mem_value});
        end
    end

    always @(negedge clk) begin
        cdb_entry_t e;
        if (!rst && bus.cdb_valid === 1'b1) begin
            if (bus.cdb_src == SRC_ALU) begin
                check_val("sb_alu_avail", 32'(qa.size() != 0), 32'd1);
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    check_val("sb_alu_idx", 32'(bus.cdb_rob_idx), 32'(e.rob_idx));
                    check_val("sb_alu_val", 32'(bus.cdb_value), 32'(e.value));
                end
            end else begin
                check_val("sb_mem_avail", 32'(qm.size() != 0), 32'd1);
                if (qm.size() != 0) begin
                    e = qm.pop_front();
                    check_val("sb_mem_idx", 32'(bus.cdb_rob_idx), 32'(e.rob_idx));
                    check_val("sb_mem_val", 32'(bus.cdb_value), 32'(e.value));
                end
            end
        end
    end

    initial begin
        logic seen_full;
        logic got_drop;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;

        // Reset state
        do_reset();
        check_val("rst_valid", 32'(bus.cdb_valid), 32'd0);
        check_val("rst_idle", 32'(bus.idle), 32'd1);
        check_val("rst_alu_rdy", 32'(bus.alu_ready), 32'd1);
        check_val("rst_mem_rdy", 32'(bus.mem_ready), 32'd1);
        check_val("rst_drop", 32'(bus.drop_err), 32'd0);
        check_val("rst_idx", 32'(bus.cdb_rob_idx), 32'd0);

        // Single uncontended ALU result
        drive(1'b1, 2'd2, 3'd5, 1'b0, 2'd0, 3'd0);
        tick();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0);
        check_val("single_valid", 32'(bus.cdb_valid), 32'd1);
        check_val("single_idx", 32'(bus.cdb_rob_idx), 32'd2);
        check_val("single_val", 32'(bus.cdb_value), 32'd5);
        check_val("single_src", 32'(bus.cdb_src), 32'd0);
        check_val("single_busy", 32'(bus.idle), 32'd0);
        tick();
        check_val("single_idle", 32'(bus.idle), 32'd1);

        // Collision right after reset
        do_reset();
        drive(1'b1, 2'd0, 3'd3, 1'b1, 2'd1, 3'd6);
        tick();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0);
        check_val("coll1_src", 32'(bus.cdb_src), 32'd0);
        check_val("coll1_idx", 32'(bus.cdb_rob_idx), 32'd0);
        check_val("coll1_val", 32'(bus.cdb_value), 32'd3);
        tick();
        check_val("coll2_valid", 32'(bus.cdb_valid), 32'd1);
        check_val("coll2_src", 32'(bus.cdb_src), 32'd1);
        check_val("coll2_idx", 32'(bus.cdb_rob_idx), 32'd1);
        check_val("coll2_val", 32'(bus.cdb_value), 32'd6);
        tick();
        check_val("coll_idle", 32'(bus.idle), 32'd1);

        // Fairness with both producers saturating and obeying ready
        do_reset();
        seen_full = 1'b0;
        drive(1'b1, 2'd0, 3'd1, 1'b1, 2'd1, 3'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("fair_valid", 32'(bus.cdb_valid), 32'd1);
            check_val("fair_src", 32'(bus.cdb_src), 32'(i % 2));
            if (!bus.alu_ready || !bus.mem_ready) seen_full = 1'b1;
            drive(bus.alu_ready, 2'(i), 3'(i + 3), bus.mem_ready, 2'(i + 1), 3'(i + 5));
        end
        check_val("fair_saw_full", 32'(seen_full), 32'd1);
        drain("fair_drain");
        check_val("fair_drop", 32'(bus.drop_err), 32'd0);

        // Overflow: MEM offered while not ready
        do_reset();
        got_drop = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(bus.alu_ready, 2'(i), 3'(i), 1'b1, 2'(i + 2), 3'(i + 1));
            if (!bus.mem_ready) begin
                check_val("ovf_drop_pre", 32'(bus.drop_err), 32'd0);
                tick();
                check_val("ovf_drop_set", 32'(bus.drop_err), 32'd1);
                got_drop = 1'b1;
                break;
            end
            tick();
        end
        check_val("ovf_reached", 32'(got_drop), 32'd1);
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_val("ovf_flush_sticky", 32'(bus.drop_err), 32'd1);
        check_val("ovf_flush_idle", 32'(bus.idle), 32'd1);
        do_reset();
        check_val("ovf_rst_clear", 32'(bus.drop_err), 32'd0);

        // Flush with pending entries in both FIFOs
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(bus.alu_ready, 2'(i), 3'(i + 1), bus.mem_ready, 2'(i + 1), 3'(i + 4));
            tick();
        end
        drive(bus.alu_ready, 2'd3, 3'd7, 1'b0, 2'd0, 3'd0);
        tick();
        check_val("flush_pending", 32'(bus.idle), 32'd0);
        drive(1'b1, 2'd1, 3'd1, 1'b1, 2'd2, 3'd2);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0);
        check_val("flush_valid", 32'(bus.cdb_valid), 32'd0);
        check_val("flush_idle", 32'(bus.idle), 32'd1);
        check_val("flush_alu_rdy", 32'(bus.alu_ready), 32'd1);
        check_val("flush_mem_rdy", 32'(bus.mem_ready), 32'd1);
        tick();
        check_val("flush_no_ghost", 32'(bus.cdb_valid), 32'd0);
        drive(1'b1, 2'd3, 3'd4, 1'b1, 2'd0, 3'd6);
        tick();
        drive(1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0);
        check_val("flush_rr_alu", 32'(bus.cdb_src), 32'd0);
        drain("flush_drain");

        // Random traffic including occasional flushes
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(bus.alu_ready & ($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom),
                  bus.mem_ready & ($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom));
            bus.flush = ($urandom_range(0, 49) == 0);
            tick();
        end
        drain("rand_drain");
        tick();
        check_val("sb_alu_left", 32'(qa.size()), 32'd0);
        check_val("sb_mem_left", 32'(qm.size()), 32'd0);
        check_val("rand_drop", 32'(bus.drop_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
